// File: rtl/ssp_pkg.sv
// Shared constants and types for the synchronous serial port FIFOs.
package ssp_pkg;

    localparam int unsigned SSP_DATA_WIDTH      = 8;
    localparam int unsigned SSP_FIFO_DEPTH      = 4;
    localparam int unsigned SSP_FIFO_ADDR_WIDTH = 2;

    typedef logic [SSP_DATA_WIDTH-1:0] ssp_byte_t;

endpackage

// File: rtl/ssp_tx_fifo.sv
// SSP transmit FIFO: buffers APB-written bytes for the serial engine.
// TXDATA is show-ahead and the transmit interrupt signals a full buffer.
module ssp_tx_fifo
    import ssp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SSP_DATA_WIDTH,
    parameter int unsigned DEPTH      = SSP_FIFO_DEPTH,
    parameter int unsigned ADDR_WIDTH = SSP_FIFO_ADDR_WIDTH
) (
    input  logic                  PCLK,
    input  logic                  CLEAR,
    input  logic                  PSEL,
    input  logic                  PWRITE,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    input  logic                  TX_POP,
    output logic [DATA_WIDTH-1:0] TXDATA,
    output logic                  TX_EMPTY,
    output logic                  TX_FULL,
    output logic                  SSPTXINTR
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  wr_acc;
    logic                  rd_acc;

    // Accepts are qualified by flags decoded from registered count only.
    assign wr_acc = PSEL & PWRITE & ~TX_FULL;
    assign rd_acc = TX_POP & ~TX_EMPTY;

    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) begin
                mem[wr_ptr] <= PWDATA;
                wr_ptr      <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign TXDATA    = mem[rd_ptr];
    assign TX_EMPTY  = (count == '0);
    assign TX_FULL   = (count == CNT_W'(DEPTH));
    assign SSPTXINTR = TX_FULL;

endmodule

// File: tb/tb_ssp_tx_fifo.sv
// Self-checking bench for ssp_tx_fifo: directed table, corner sequences
// and randomized traffic against a queue-based reference model.
module tb_ssp_tx_fifo;
    import ssp_pkg::*;

    localparam int unsigned DW    = SSP_DATA_WIDTH;
    localparam int unsigned DEPTH = SSP_FIFO_DEPTH;

    logic          PCLK = 1'b0;
    logic          CLEAR;
    logic          PSEL;
    logic          PWRITE;
    logic [DW-1:0] PWDATA;
    logic          TX_POP;
    logic [DW-1:0] TXDATA;
    logic          TX_EMPTY;
    logic          TX_FULL;
    logic          SSPTXINTR;

    int checks = 0;
    int errors = 0;

    ssp_byte_t model_q[$];

    typedef struct {
        logic      psel;
        logic      pwrite;
        ssp_byte_t d;
        logic      pop;
        ssp_byte_t exp_data;
        logic      exp_empty;
        logic      exp_full;
    } vec_t;

    vec_t vecs[15];

    ssp_tx_fifo dut (
        .PCLK      (PCLK),
        .CLEAR     (CLEAR),
        .PSEL      (PSEL),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .TX_POP    (TX_POP),
        .TXDATA    (TXDATA),
        .TX_EMPTY  (TX_EMPTY),
        .TX_FULL   (TX_FULL),
        .SSPTXINTR (SSPTXINTR)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT against the reference queue.
    task automatic model_check(input string tag);
        chk({tag, ".empty"}, 32'(TX_EMPTY), 32'(model_q.size() == 0));
        chk({tag, ".full"}, 32'(TX_FULL), 32'(model_q.size() == int'(DEPTH)));
        chk({tag, ".intr"}, 32'(SSPTXINTR), 32'(model_q.size() == int'(DEPTH)));
        if (model_q.size() != 0) begin
            chk({tag, ".data"}, 32'(TXDATA), 32'(model_q[0]));
        end
    endtask

    // One clock of stimulus; the model evaluates accepts on pre-edge contents.
    task automatic cycle(input logic psel, input logic pwrite, input ssp_byte_t d,
                         input logic pop, input string tag);
        bit w;
        bit r;
        PSEL   = psel;
        PWRITE = pwrite;
        PWDATA = d;
        TX_POP = pop;
        @(posedge PCLK);
        w = psel && pwrite && (model_q.size() < int'(DEPTH));
        r = pop && (model_q.size() > 0);
        if (r) void'(model_q.pop_front());
        if (w) model_q.push_back(d);
        #1;
        model_check(tag);
    endtask

    task automatic idle_inputs();
        PSEL   = 1'b0;
        PWRITE = 1'b0;
        PWDATA = '0;
        TX_POP = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        CLEAR = 1'b1;
        @(posedge PCLK);
        #1;
        CLEAR = 1'b0;
        model_q.delete();
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 8'hA1, 1'b0, 8'hA1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 8'h11, 1'b0, 8'h11, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 8'h22, 1'b0, 8'h11, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 8'h33, 1'b0, 8'h11, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 8'h44, 1'b0, 8'h11, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 8'h55, 1'b0, 8'h11, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h22, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h33, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h44, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 8'hFF, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 8'h88, 1'b1, 8'h88, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};

        idle_inputs();
        CLEAR = 1'b1;
        #12;
        chk("rst.data", 32'(TXDATA), 32'h0);
        chk("rst.empty", 32'(TX_EMPTY), 32'h1);
        chk("rst.full", 32'(TX_FULL), 32'h0);
        chk("rst.intr", 32'(SSPTXINTR), 32'h0);
        @(posedge PCLK);
        #1;
        CLEAR = 1'b0;
        cycle(1'b0, 1'b0, 8'h00, 1'b0, "idle");
        chk("idle.data", 32'(TXDATA), 32'h0);

        // Directed table; data is only meaningful while not empty.
        for (int i = 0; i < 15; i++) begin
            cycle(vecs[i].psel, vecs[i].pwrite, vecs[i].d, vecs[i].pop, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.empty_c", i), 32'(TX_EMPTY), 32'(vecs[i].exp_empty));
            chk($sformatf("vec%0d.full_c", i), 32'(TX_FULL), 32'(vecs[i].exp_full));
            if (!vecs[i].exp_empty) begin
                chk($sformatf("vec%0d.data_c", i), 32'(TXDATA), 32'(vecs[i].exp_data));
            end
        end

        // Asynchronous clear between edges with two words stored.
        cycle(1'b1, 1'b1, 8'hC1, 1'b0, "aclr.w0");
        cycle(1'b1, 1'b1, 8'hC2, 1'b0, "aclr.w1");
        idle_inputs();
        #2;
        CLEAR = 1'b1;
        #1;
        chk("aclr.data", 32'(TXDATA), 32'h0);
        chk("aclr.empty", 32'(TX_EMPTY), 32'h1);
        chk("aclr.full", 32'(TX_FULL), 32'h0);
        #2;
        CLEAR = 1'b0;
        model_q.delete();
        cycle(1'b0, 1'b0, 8'h00, 1'b0, "aclr.after");
        chk("aclr.after_empty", 32'(TX_EMPTY), 32'h1);

        // Simultaneous write and pop with two stored, then with the FIFO full.
        cycle(1'b1, 1'b1, 8'h01, 1'b0, "sim.w1");
        cycle(1'b1, 1'b1, 8'h02, 1'b0, "sim.w2");
        cycle(1'b1, 1'b1, 8'h66, 1'b1, "sim.wp");
        chk("sim.head_02", 32'(TXDATA), 32'h02);
        cycle(1'b1, 1'b1, 8'h03, 1'b0, "sim.w3");
        cycle(1'b1, 1'b1, 8'h04, 1'b0, "sim.w4");
        chk("sim.full", 32'(TX_FULL), 32'h1);
        cycle(1'b1, 1'b1, 8'h77, 1'b1, "sim.full_wp");
        chk("sim.full_wp_head", 32'(TXDATA), 32'h66);
        chk("sim.full_wp_notfull", 32'(TX_FULL), 32'h0);
        cycle(1'b0, 1'b0, 8'h00, 1'b1, "sim.p1");
        chk("sim.p1_head", 32'(TXDATA), 32'h03);
        cycle(1'b0, 1'b0, 8'h00, 1'b1, "sim.p2");
        chk("sim.p2_head", 32'(TXDATA), 32'h04);
        cycle(1'b0, 1'b0, 8'h00, 1'b1, "sim.p3");
        chk("sim.drained", 32'(TX_EMPTY), 32'h1);

        // Pointer wrap: write 3, pop 3, write 4, pop 4.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, ssp_byte_t'(8'hB0 + i), 1'b0, "wrap.w3");
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1, "wrap.p3");
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, ssp_byte_t'(8'hD0 + i), 1'b0, "wrap.w4");
        chk("wrap.full", 32'(TX_FULL), 32'h1);
        chk("wrap.head", 32'(TXDATA), 32'hD0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wrap.order%0d", i), 32'(TXDATA), 32'(8'hD0 + i));
            cycle(1'b0, 1'b0, 8'h00, 1'b1, "wrap.p4");
        end
        chk("wrap.empty", 32'(TX_EMPTY), 32'h1);

        // Randomized traffic against the reference queue.
        do_reset();
        for (int i = 0; i < 500; i++) begin
            cycle(($urandom % 4) != 0, ($urandom % 4) != 0, ssp_byte_t'($urandom),
                  ($urandom % 2) == 1, "rand");
        end

        idle_inputs();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
